// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared types and constants for the system-bus slave-select logic.
//   state_e     : slave-select FSM states
//   DEV_*       : device codes carried in the leading serial address bits
//   NUM_SLAVES  : number of slaves hanging off the forward path
// -----------------------------------------------------------------------------
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    CHECK   = 3'd2,
    CONNECT = 3'd3,
    ERR     = 3'd4
  } state_e;

  localparam logic [1:0] DEV_S0  = 2'b00;
  localparam logic [1:0] DEV_S1  = 2'b01;
  localparam logic [1:0] DEV_S2  = 2'b10;
  localparam logic [1:0] DEV_INV = 2'b11;

  localparam int NUM_SLAVES = 3;

endpackage

// File: rtl/addr_shift_in.sv
// -----------------------------------------------------------------------------
// addr_shift_in
// Serial-in / parallel-out shift register for the device-select bits.
// The first bit received ends up as the MSB of code.
//   clk, rstn : clock, asynchronous active-low reset
//   en        : shift din in this cycle
//   clr       : clear register and bit counter (wins over en)
//   din       : serial bit
//   code      : assembled device code
//   last      : the bit shifted on this cycle completes the code
// -----------------------------------------------------------------------------
module addr_shift_in #(
  parameter int DEVICE_BITS = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  input  logic                   clr,
  input  logic                   din,
  output logic [DEVICE_BITS-1:0] code,
  output logic                   last
);

  localparam int CW = (DEVICE_BITS > 1) ? $clog2(DEVICE_BITS) : 1;

  logic [DEVICE_BITS-1:0] code_q, code_d, shifted;
  logic [CW-1:0]          cnt_q, cnt_d;

  generate
    if (DEVICE_BITS == 1) begin : g_one
      assign shifted = din;
    end else begin : g_many
      assign shifted = {code_q[DEVICE_BITS-2:0], din};
    end
  endgenerate

  assign last = (cnt_q == CW'(DEVICE_BITS - 1));
  assign code = code_q;

  // Counter wraps to zero on the final bit so the next transaction starts
  // clean while the completed code stays available for decode.
  always_comb begin
    code_d = code_q;
    cnt_d  = cnt_q;
    if (clr) begin
      code_d = '0;
      cnt_d  = '0;
    end else if (en) begin
      code_d = shifted;
      cnt_d  = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      code_q <= '0;
      cnt_q  <= '0;
    end else begin
      code_q <= code_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_slave_select.sv
// -----------------------------------------------------------------------------
// bus_slave_select
// Forward-path address decoder / slave-select controller. Shifts in the serial
// device code, waits for the addressed slave to be ready, then gates mvalid to
// that slave only and holds dsel for the read-data return mux.
//   clk, rstn : clock, asynchronous active-low reset
//   mvalid    : master valid
//   maddr     : master serial address/data bit
//   s_ready   : per-slave ready flags
//   s_done    : per-slave end-of-transaction pulses
//   s_valid   : per-slave gated mvalid
//   dsel      : read-mux select (slave index)
//   ack       : one-cycle pulse, target slave accepted
//   err       : one-cycle pulse, invalid device code
//   busy      : controller not idle
// Build option: define BUS_SEL_ERR_EN to reject code 11 through the ERR state;
// otherwise code 11 aliases to slave2 and err is tied low.
// -----------------------------------------------------------------------------
module bus_slave_select
  import bus_pkg::*;
#(
  parameter int DEVICE_BITS = 2,
  parameter int NUM_SLAVES  = bus_pkg::NUM_SLAVES
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  mvalid,
  input  logic                  maddr,
  input  logic [NUM_SLAVES-1:0] s_ready,
  input  logic [NUM_SLAVES-1:0] s_done,
  output logic [NUM_SLAVES-1:0] s_valid,
  output logic [1:0]            dsel,
  output logic                  ack,
  output logic                  err,
  output logic                  busy
);

  state_e state_q, state_d;
  logic [1:0] dsel_q, dsel_d;
  logic       ack_q, busy_q;
  logic       shift_en, shift_clr, shift_last;
  logic [DEVICE_BITS-1:0] shift_code;
  logic [1:0] dev_code, target;
  logic       tgt_ready, done_sel;

  addr_shift_in #(.DEVICE_BITS(DEVICE_BITS)) u_shift (
    .clk  (clk),
    .rstn (rstn),
    .en   (shift_en),
    .clr  (shift_clr),
    .din  (maddr),
    .code (shift_code),
    .last (shift_last)
  );

  generate
    if (DEVICE_BITS == 1) begin : g_code1
      assign dev_code = {1'b0, shift_code};
    end else begin : g_coden
      assign dev_code = shift_code[1:0];
    end
  endgenerate

  // Slave addressed by the decoded code; the invalid code either goes to ERR
  // or is folded onto slave2.
`ifdef BUS_SEL_ERR_EN
  assign target = dev_code;
`else
  assign target = (dev_code == DEV_INV) ? DEV_S2 : dev_code;
`endif

  always_comb begin
    tgt_ready = 1'b0;
    done_sel  = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (target == 2'(i)) tgt_ready = s_ready[i];
      if (dsel_q == 2'(i)) done_sel  = s_done[i];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      dsel_q  <= DEV_S0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dsel_q  <= dsel_d;
      ack_q   <= (state_q == CHECK) && (state_d == CONNECT);
      busy_q  <= (state_d != IDLE);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    dsel_d  = dsel_q;
    case (state_q)
      IDLE:    if (mvalid) state_d = shift_last ? CHECK : ADDR;
      ADDR: begin
        if (!mvalid)        state_d = IDLE;
        else if (shift_last) state_d = CHECK;
      end
      CHECK: begin
`ifdef BUS_SEL_ERR_EN
        if (dev_code == DEV_INV) begin
          state_d = ERR;
        end else
`endif
        if (tgt_ready) begin
          state_d = CONNECT;
          dsel_d  = target;
        end
      end
      // s_done has priority over mvalid: the cycle after done is always IDLE.
      CONNECT: if (done_sel) state_d = IDLE;
`ifdef BUS_SEL_ERR_EN
      ERR:     state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    shift_en  = mvalid && ((state_q == IDLE) || (state_q == ADDR));
    shift_clr = (state_q == ADDR) && !mvalid;
    s_valid   = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      s_valid[i] = (state_q == CONNECT) && (dsel_q == 2'(i)) && mvalid;
    end
  end

`ifdef BUS_SEL_ERR_EN
  logic err_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_q <= 1'b0;
    else       err_q <= (state_d == ERR);
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign dsel = dsel_q;
  assign ack  = ack_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_bus_slave_select.sv
// -----------------------------------------------------------------------------
// tb_bus_slave_select
// Transaction-level bench: each transaction is described by its device bits,
// how long the target slave stays busy, how many data cycles follow and whether
// mvalid coincides with done. Expected outputs come from the bus rules: two
// address cycles, CHECK until the target is ready, ack on the first connected
// cycle, s_valid only toward the addressed slave, IDLE after its done.
// -----------------------------------------------------------------------------
module tb_bus_slave_select;

  logic       clk = 1'b0;
  logic       rstn;
  logic       mvalid, maddr;
  logic [2:0] s_ready, s_done, s_valid;
  logic [1:0] dsel;
  logic       ack, err, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_dsel;

  always #5 clk = ~clk;

  bus_slave_select #(.DEVICE_BITS(2), .NUM_SLAVES(3)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .mvalid  (mvalid),
    .maddr   (maddr),
    .s_ready (s_ready),
    .s_done  (s_done),
    .s_valid (s_valid),
    .dsel    (dsel),
    .ack     (ack),
    .err     (err),
    .busy    (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven 1 time unit after the rising edge, outputs sampled 1 later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic b0, input logic b1, input int wait_cyc,
                     input int data_len, input bit done_with_valid);
    int  code, tgt;
    bit  is_err;
    code = {30'd0, b0, b1};
`ifdef BUS_SEL_ERR_EN
    is_err = (code == 3);
`else
    is_err = 1'b0;
`endif
    tgt = (code == 3) ? 2 : code;

    // cycle 0 / 1: device bits, MSB first
    mvalid = 1'b1; maddr = b0; s_done = 3'b000;
    #1 check_val("c0_busy", busy, 0);
    next_cycle();
    maddr = b1;
    #1 check_val("c1_busy", busy, 1);
    check_val("c1_ack", ack, 0);
    next_cycle();

    if (is_err) begin
      mvalid = 1'($urandom); s_ready = 3'($urandom);
      #1 check_val("e2_err", err, 0);
      check_val("e2_busy", busy, 1);
      next_cycle();
      #1 check_val("e3_err", err, 1);
      check_val("e3_ack", ack, 0);
      check_val("e3_svalid", s_valid, 0);
      check_val("e3_dsel", dsel, exp_dsel);
      next_cycle();
      mvalid = 1'b0;
      #1 check_val("e4_err", err, 0);
      check_val("e4_busy", busy, 0);
      check_val("e4_dsel", dsel, exp_dsel);
      next_cycle();
      $display("txn code=%0d -> err", code);
      return;
    end

    // CHECK: target held not-ready for wait_cyc cycles; mvalid is don't-care
    for (int w = 0; w <= wait_cyc; w++) begin
      s_ready = 3'($urandom);
      s_ready[tgt] = (w == wait_cyc);
      mvalid = 1'($urandom);
      #1 check_val("chk_ack", ack, 0);
      check_val("chk_err", err, 0);
      check_val("chk_busy", busy, 1);
      check_val("chk_svalid", s_valid, 0);
      check_val("chk_dsel", dsel, exp_dsel);
      next_cycle();
    end
    exp_dsel = tgt;

    // CONNECT: other slaves' done pulses are noise; last cycle carries done
    for (int k = 0; k <= data_len; k++) begin
      bit lastc;
      lastc  = (k == data_len);
      mvalid = lastc ? done_with_valid : 1'($urandom);
      maddr  = 1'($urandom);
      s_done = 3'($urandom);
      s_done[tgt] = lastc;
      #1 check_val("con_ack", ack, (k == 0) ? 1 : 0);
      check_val("con_err", err, 0);
      check_val("con_busy", busy, 1);
      check_val("con_dsel", dsel, exp_dsel);
      check_val("con_svalid", s_valid, mvalid ? (1 << tgt) : 0);
      next_cycle();
    end

    // back in IDLE: dsel retained
    mvalid = 1'b0; s_done = 3'b000;
    #1 check_val("idle_busy", busy, 0);
    check_val("idle_ack", ack, 0);
    check_val("idle_svalid", s_valid, 0);
    check_val("idle_dsel", dsel, exp_dsel);
    next_cycle();
    $display("txn code=%0d wait=%0d len=%0d -> slave%0d", code, wait_cyc, data_len, tgt);
  endtask

  initial begin
    rstn = 1'b0; mvalid = 1'b0; maddr = 1'b0; s_ready = 3'b000; s_done = 3'b000;
    exp_dsel = 0;
    #12;
    check_val("rst_svalid", s_valid, 0);
    check_val("rst_dsel", dsel, 0);
    check_val("rst_ack", ack, 0);
    check_val("rst_err", err, 0);
    check_val("rst_busy", busy, 0);
    @(posedge clk); #1 rstn = 1'b1;
    next_cycle();

    txn(1'b0, 1'b1, 0, 2, 1'b0);
    txn(1'b1, 1'b0, 5, 1, 1'b0);

    // abort after one device bit
    mvalid = 1'b1; maddr = 1'b1;
    next_cycle();
    mvalid = 1'b0;
    #1 check_val("ab_busy1", busy, 1);
    next_cycle();
    #1 check_val("ab_busy2", busy, 0);
    check_val("ab_ack", ack, 0);
    check_val("ab_err", err, 0);
    check_val("ab_svalid", s_valid, 0);
    next_cycle();
    $display("txn aborted after 1 bit");
    txn(1'b0, 1'b0, 0, 1, 1'b0);

    txn(1'b1, 1'b1, 0, 1, 1'b0);
    txn(1'b0, 1'b1, 0, 3, 1'b1);

    // reset during CONNECT
    s_ready = 3'b111; s_done = 3'b000;
    mvalid = 1'b1; maddr = 1'b0; next_cycle();
    maddr = 1'b1; next_cycle();
    mvalid = 1'b0; next_cycle();
    mvalid = 1'b1;
    #1 check_val("pr_svalid", s_valid, 3'b010);
    #1 rstn = 1'b0;
    #1 check_val("ar_svalid", s_valid, 0);
    check_val("ar_busy", busy, 0);
    check_val("ar_dsel", dsel, 0);
    check_val("ar_ack", ack, 0);
    exp_dsel = 0;
    mvalid = 1'b0;
    next_cycle();
    rstn = 1'b1;
    next_cycle();
    $display("txn reset during CONNECT");
    txn(1'b1, 1'b0, 0, 1, 1'b0);

    for (int t = 0; t < 40; t++) begin
      txn(1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 4),
          1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
